// File: rtl/apu_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : apu_frame_sequencer
// Brief    : Programmable frame-rate prescaler plus 8-step sequencer that
//            emits single-cycle length / sweep / envelope strobes.
// Revision : 1.0
// ============================================================================
module apu_frame_sequencer #(
    parameter int          W              = 13,
    parameter int unsigned DEFAULT_PERIOD = 8191
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         sync,
    input  logic [W-1:0] period,
    output logic [2:0]   step,
    output logic         frame_tick,
    output logic         length_tick,
    output logic         sweep_tick,
    output logic         env_tick
);

    localparam logic [W-1:0] c_DEF_PERIOD = W'(DEFAULT_PERIOD);

    logic [W-1:0] r_cnt;
    logic [W-1:0] r_per_q;
    logic [2:0]   r_step;
    logic         r_frame_tick;
    logic         r_length_tick;
    logic         r_sweep_tick;
    logic         r_env_tick;

    logic         w_terminal;

    assign w_terminal = (r_cnt == r_per_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_per_q       <= c_DEF_PERIOD;
            r_step        <= 3'd0;
            r_frame_tick  <= 1'b0;
            r_length_tick <= 1'b0;
            r_sweep_tick  <= 1'b0;
            r_env_tick    <= 1'b0;
        end else begin
            r_frame_tick  <= 1'b0;
            r_length_tick <= 1'b0;
            r_sweep_tick  <= 1'b0;
            r_env_tick    <= 1'b0;
            if (sync) begin
                r_cnt   <= '0;
                r_step  <= 3'd0;
                r_per_q <= period;
            end else if (!en) begin
                // Counter and step freeze, but the period may be reprogrammed.
                r_per_q <= period;
            end else if (w_terminal) begin
                r_cnt         <= '0;
                r_step        <= r_step + 3'd1;
                r_per_q       <= period;
                r_frame_tick  <= 1'b1;
                // Strobes decode the step being left: L,-,L+S,-,L,-,L+S,E.
                r_length_tick <= ~r_step[0];
                r_sweep_tick  <= (r_step[1:0] == 2'b10);
                r_env_tick    <= (r_step == 3'd7);
            end else begin
                r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign step        = r_step;
    assign frame_tick  = r_frame_tick;
    assign length_tick = r_length_tick;
    assign sweep_tick  = r_sweep_tick;
    assign env_tick    = r_env_tick;

endmodule
`default_nettype wire

// File: tb/tb_apu_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_apu_frame_sequencer
// Brief    : Directed self-checking bench for apu_frame_sequencer.
// Revision : 1.0
// ============================================================================
module tb_apu_frame_sequencer;

    localparam int W = 13;

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b0;
    logic         en     = 1'b0;
    logic         sync   = 1'b0;
    logic [W-1:0] period = '0;
    logic [2:0]   step;
    logic         frame_tick;
    logic         length_tick;
    logic         sweep_tick;
    logic         env_tick;

    int checks = 0;
    int errors = 0;

    // Strobe tables indexed by the step being left.
    logic [7:0] tab_len = 8'b0101_0101;
    logic [7:0] tab_swp = 8'b0100_0100;
    logic [7:0] tab_env = 8'b1000_0000;

    logic [6:0] obs;
    logic [6:0] exp_v;

    apu_frame_sequencer #(.W(W), .DEFAULT_PERIOD(8191)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .sync        (sync),
        .period      (period),
        .step        (step),
        .frame_tick  (frame_tick),
        .length_tick (length_tick),
        .sweep_tick  (sweep_tick),
        .env_tick    (env_tick)
    );

    always #5 clk = ~clk;

    assign obs = {step, frame_tick, length_tick, sweep_tick, env_tick};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_sync(input logic [W-1:0] p);
        sync   = 1'b1;
        en     = 1'b1;
        period = p;
        tick();
        sync   = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("FAIL reset_state got=%b exp=%b", obs, 7'b0);
        end
        rst_n = 1'b1;
        do_sync(3);
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("FAIL after_sync got=%b exp=%b", obs, 7'b0);
        end
    endtask

    task automatic test_main();
        for (int i = 1; i <= 32; i++) begin
            int k;
            tick();
            k = i / 4;
            if (i % 4 == 0)
                exp_v = {3'(k % 8), 1'b1, tab_len[(k-1)%8], tab_swp[(k-1)%8], tab_env[(k-1)%8]};
            else
                exp_v = {3'(k % 8), 4'b0};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL main_seq cyc=%0d got=%b exp=%b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_period_change();
        // Expected {step,F,L,S,E} for 8 edges; period drops to 1 after edge 2.
        logic [6:0] exp_tab [8];
        exp_tab[0] = {3'd0, 4'b0000};
        exp_tab[1] = {3'd0, 4'b0000};
        exp_tab[2] = {3'd0, 4'b0000};
        exp_tab[3] = {3'd1, 4'b1100};
        exp_tab[4] = {3'd1, 4'b0000};
        exp_tab[5] = {3'd2, 4'b1000};
        exp_tab[6] = {3'd2, 4'b0000};
        exp_tab[7] = {3'd3, 4'b1110};
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 1) period = 1;
            checks++;
            if (obs !== exp_tab[i]) begin
                errors++;
                $display("FAIL period_change cyc=%0d got=%b exp=%b", i, obs, exp_tab[i]);
            end
        end
    endtask

    task automatic test_en_freeze();
        do_sync(3);
        tick();
        tick();
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (obs !== 7'b0) begin
                errors++;
                $display("FAIL en_freeze cyc=%0d got=%b exp=%b", i, obs, 7'b0);
            end
        end
        en = 1'b1;
        tick();
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("FAIL reenable_1 got=%b exp=%b", obs, 7'b0);
        end
        tick();
        checks++;
        if (obs !== {3'd1, 4'b1100}) begin
            errors++;
            $display("FAIL reenable_2 got=%b exp=%b", obs, {3'd1, 4'b1100});
        end
        // Drop en exactly when cnt reaches terminal.
        tick(); tick(); tick();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs !== {3'd1, 4'b0000}) begin
                errors++;
                $display("FAIL term_suppress cyc=%0d got=%b exp=%b", i, obs, {3'd1, 4'b0000});
            end
        end
        en = 1'b1;
        tick();
        checks++;
        if (obs !== {3'd2, 4'b1000}) begin
            errors++;
            $display("FAIL term_resume got=%b exp=%b", obs, {3'd2, 4'b1000});
        end
    endtask

    task automatic test_sync();
        do_sync(3);
        for (int i = 0; i < 22; i++) tick();
        checks++;
        if (step !== 3'd5) begin
            errors++;
            $display("FAIL sync_setup step got=%0d exp=%0d", step, 5);
        end
        sync = 1'b1;
        tick();
        sync = 1'b0;
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("FAIL sync_clear got=%b exp=%b", obs, 7'b0);
        end
        for (int i = 1; i <= 4; i++) begin
            tick();
            exp_v = (i == 4) ? {3'd1, 4'b1100} : 7'b0;
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL sync_resume cyc=%0d got=%b exp=%b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_period_zero();
        do_sync(0);
        for (int i = 1; i <= 16; i++) begin
            tick();
            exp_v = {3'(i % 8), 1'b1, tab_len[(i-1)%8], tab_swp[(i-1)%8], tab_env[(i-1)%8]};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL period_zero cyc=%0d got=%b exp=%b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_async_reset();
        int n;
        tick();
        checks++;
        if (obs !== {3'd1, 4'b1100}) begin
            errors++;
            $display("FAIL pre_reset got=%b exp=%b", obs, {3'd1, 4'b1100});
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("FAIL async_reset got=%b exp=%b", obs, 7'b0);
        end
        #1;
        rst_n = 1'b1;
        en    = 1'b1;
        n = 0;
        for (int i = 1; i <= 9000; i++) begin
            tick();
            if (frame_tick) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n != 8192) begin
            errors++;
            $display("FAIL default_frame_len got=%0d exp=%0d", n, 8192);
        end
        checks++;
        if (obs !== {3'd1, 4'b1100}) begin
            errors++;
            $display("FAIL default_frame_ticks got=%b exp=%b", obs, {3'd1, 4'b1100});
        end
    endtask

    initial begin
        test_reset();
        test_main();
        test_period_change();
        test_en_freeze();
        test_sync();
        test_period_zero();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
